// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus host arbiter.
// Mode is picked at build time by BUS_ARB_FIXED_PRIO_EN.
package bus_arb_pkg;

    typedef enum logic {
        ARB_ROUND_ROBIN,
        ARB_FIXED_PRIO
    } arb_mode_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// Response-ID FIFO: remembers which host owns each outstanding transaction.
// Push and pop may coincide, including when full.
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = idx_width(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = (wptr_q == PW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = (rptr_q == PW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push) begin
                mem_q[wptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// N-host to one-device bus arbiter with sticky selection and in-order responses.
// Define BUS_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NrHosts-1:0]                    host_req_i,
    input  logic [NrHosts-1:0]                    host_we_i,
    input  logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i,
    input  logic [NrHosts-1:0][3:0]               host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i,
    output logic [NrHosts-1:0]                    host_gnt_o,
    output logic [NrHosts-1:0]                    host_rvalid_o,
    output logic [NrHosts-1:0]                    host_err_o,
    output logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o,
    output logic                                  dev_req_o,
    output logic                                  dev_we_o,
    output logic [AddressWidth-1:0]               dev_addr_o,
    output logic [3:0]                            dev_be_o,
    output logic [DataWidth-1:0]                  dev_wdata_o,
    input  logic                                  dev_gnt_i,
    input  logic                                  dev_rvalid_i,
    input  logic                                  dev_err_i,
    input  logic [DataWidth-1:0]                  dev_rdata_i
);

    localparam int unsigned IW = idx_width(NrHosts);
`ifdef BUS_ARB_FIXED_PRIO_EN
    localparam arb_mode_e Mode = ARB_FIXED_PRIO;
`else
    localparam arb_mode_e Mode = ARB_ROUND_ROBIN;
`endif

    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] sel_q, sel_d;
    logic          sticky_q, sticky_d;
    logic [IW-1:0] arb_idx, sel, head;
    logic          found, keep, full, empty;
    logic          pop, req, grant;
    int            cand;

    always_comb begin
        arb_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < int'(NrHosts); i++) begin
            if (Mode == ARB_FIXED_PRIO) cand = i;
            else cand = (int'(last_q) + 1 + i) % int'(NrHosts);
            if (!found && host_req_i[IW'(cand)]) begin
                found   = 1'b1;
                arb_idx = IW'(cand);
            end
        end
    end

    // An ungranted request stays with its host until granted or withdrawn.
    assign keep  = sticky_q && host_req_i[sel_q];
    assign sel   = keep ? sel_q : arb_idx;
    assign pop   = rst_ni && dev_rvalid_i && !empty;
    assign req   = rst_ni && (|host_req_i) && (!full || pop);
    assign grant = req && dev_gnt_i;

    always_comb begin
        sticky_d = req && !dev_gnt_i;
        sel_d    = req ? sel : sel_q;
        last_d   = grant ? sel : last_q;
    end

    always_comb begin
        dev_req_o     = req;
        dev_we_o      = 1'b0;
        dev_addr_o    = '0;
        dev_be_o      = '0;
        dev_wdata_o   = '0;
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        if (req) begin
            dev_we_o    = host_we_i[sel];
            dev_addr_o  = host_addr_i[sel];
            dev_be_o    = host_be_i[sel];
            dev_wdata_o = host_wdata_i[sel];
        end
        if (grant) host_gnt_o[sel] = 1'b1;
        if (pop) begin
            host_rvalid_o[head] = 1'b1;
            host_err_o[head]    = dev_err_i;
            host_rdata_o[head]  = dev_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q   <= IW'(NrHosts - 1);
            sel_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            last_q   <= last_d;
            sel_q    <= sel_d;
            sticky_q <= sticky_d;
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .data_i  (sel),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter (default round-robin build).
module tb_bus_host_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        host_req, host_we;
    logic [1:0][31:0]  host_addr, host_wdata;
    logic [1:0][3:0]   host_be;
    logic [1:0]        host_gnt, host_rvalid, host_err;
    logic [1:0][31:0]  host_rdata;
    logic              dev_req, dev_we, dev_gnt, dev_rvalid, dev_err;
    logic [31:0]       dev_addr, dev_wdata, dev_rdata;
    logic [3:0]        dev_be;

    always #5 clk = ~clk;

    bus_host_arbiter #(
        .NrHosts(2), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_we_i(host_we),
        .host_addr_i(host_addr), .host_be_i(host_be),
        .host_wdata_i(host_wdata),
        .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
        .host_err_o(host_err), .host_rdata_o(host_rdata),
        .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_addr_o(dev_addr),
        .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
        .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
        .dev_err_i(dev_err), .dev_rdata_i(dev_rdata)
    );

    typedef struct {
        string       tag;
        logic        rst;
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic        exp_req;
        int          exp_sel;
    } vec_t;

    vec_t tbl[$];
    int   ids[$];
    int   checks = 0;
    int   failures = 0;

    function automatic void add(string tag, logic rst, logic [1:0] req,
                                logic gnt, logic rv, logic err,
                                logic [31:0] rd, logic er, int es);
        vec_t v;
        v = '{tag, rst, req, gnt, rv, err, rd, er, es};
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        logic [1:0]  exp_rv, exp_er, exp_gnt;
        logic [31:0] exp_rd [2];
        int          h;
        @(negedge clk);
        rst_n      = v.rst;
        host_req   = v.req;
        dev_gnt    = v.gnt;
        dev_rvalid = v.rv;
        dev_err    = v.err;
        dev_rdata  = v.rdata;
        #1;
        exp_rv = '0;
        exp_er = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        if (!v.rst) ids.delete();
        else if (v.rv && ids.size() > 0) begin
            h = ids.pop_front();
            exp_rv[h] = 1'b1;
            exp_er[h] = v.err;
            exp_rd[h] = v.rdata;
        end
        exp_gnt = (v.exp_req && v.gnt) ? 2'(1 << v.exp_sel) : 2'b00;
        chk({v.tag, "_req"}, 64'(dev_req), 64'(v.exp_req));
        chk({v.tag, "_gnt"}, 64'(host_gnt), 64'(exp_gnt));
        chk({v.tag, "_rvalid"}, 64'(host_rvalid), 64'(exp_rv));
        chk({v.tag, "_err"}, 64'(host_err), 64'(exp_er));
        chk({v.tag, "_rdata0"}, 64'(host_rdata[0]), 64'(exp_rd[0]));
        chk({v.tag, "_rdata1"}, 64'(host_rdata[1]), 64'(exp_rd[1]));
        if (v.exp_req) begin
            chk({v.tag, "_addr"}, 64'(dev_addr),
                64'(32'h0010_0000 * (v.exp_sel + 1)));
            chk({v.tag, "_we"}, 64'(dev_we), 64'(v.exp_sel == 1));
            chk({v.tag, "_wdata"}, 64'(dev_wdata),
                64'(32'hC0DE_0000 + v.exp_sel));
        end else begin
            chk({v.tag, "_addr0"}, 64'(dev_addr), 64'd0);
        end
        if (exp_gnt != 2'b00) ids.push_back(v.exp_sel);
    endtask

    initial begin
        rst_n      = 1'b0;
        host_req   = '0;
        host_we    = 2'b10;
        host_addr  = {32'h0020_0000, 32'h0010_0000};
        host_be    = {4'h3, 4'hF};
        host_wdata = {32'hC0DE_0001, 32'hC0DE_0000};
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_err    = 1'b0;
        dev_rdata  = '0;

        // Alternating grants with one-cycle responses.
        add("a_rst", 0, 2'b11, 1, 0, 0, 0, 0, 0);
        add("a0", 1, 2'b11, 1, 0, 0, 32'h0, 1, 0);
        add("a1", 1, 2'b11, 1, 1, 0, 32'hA1, 1, 1);
        add("a2", 1, 2'b11, 1, 1, 1, 32'hA2, 1, 0);
        add("a3", 1, 2'b11, 1, 1, 0, 32'hA3, 1, 1);
        add("a4", 1, 2'b00, 0, 1, 0, 32'hA4, 0, 0);
        // Outstanding limit, push+pop when full, empty-FIFO rvalid.
        add("b_rst", 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("b0", 1, 2'b11, 1, 0, 0, 0, 1, 0);
        add("b1", 1, 2'b11, 1, 0, 0, 0, 1, 1);
        add("b2", 1, 2'b11, 1, 0, 0, 0, 0, 0);
        add("b3", 1, 2'b11, 1, 0, 0, 0, 0, 0);
        add("b4", 1, 2'b11, 1, 1, 0, 32'hB4, 1, 0);
        add("b5", 1, 2'b11, 1, 0, 0, 0, 0, 0);
        add("b6", 1, 2'b11, 1, 1, 0, 32'hB6, 1, 1);
        add("b7", 1, 2'b00, 0, 1, 0, 32'hB7, 0, 0);
        add("b8", 1, 2'b00, 0, 1, 1, 32'hB8, 0, 0);
        add("b9", 1, 2'b00, 0, 1, 0, 32'hDEADBEEF, 0, 0);
        add("b10", 1, 2'b11, 1, 0, 0, 0, 1, 0);
        add("b11", 1, 2'b11, 1, 0, 0, 0, 1, 1);
        add("b12", 1, 2'b11, 1, 0, 0, 0, 0, 0);
        add("b13", 1, 2'b00, 0, 1, 0, 32'hB13, 0, 0);
        add("b14", 1, 2'b00, 0, 1, 0, 32'hB14, 0, 0);
        // Sticky selection and dropping it on withdrawal.
        add("c_rst", 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("c0", 1, 2'b10, 0, 0, 0, 0, 1, 1);
        add("c1", 1, 2'b11, 0, 0, 0, 0, 1, 1);
        add("c2", 1, 2'b11, 0, 0, 0, 0, 1, 1);
        add("c3", 1, 2'b11, 1, 0, 0, 0, 1, 1);
        add("c4", 1, 2'b11, 1, 1, 0, 32'hC4, 1, 0);
        add("c5", 1, 2'b00, 0, 1, 0, 32'hC5, 0, 0);
        add("c6", 1, 2'b10, 0, 0, 0, 0, 1, 1);
        add("c7", 1, 2'b01, 0, 0, 0, 0, 1, 0);
        add("c8", 1, 2'b01, 1, 0, 0, 0, 1, 0);
        add("c9", 1, 2'b00, 0, 1, 0, 32'hC9, 0, 0);
        // Reset with a transaction in flight.
        add("e_rst", 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("e0", 1, 2'b01, 1, 0, 0, 0, 1, 0);
        add("e1", 0, 2'b01, 1, 0, 0, 0, 0, 0);
        add("e2", 1, 2'b00, 0, 1, 0, 32'h5, 0, 0);
        add("e3", 1, 2'b11, 1, 0, 0, 0, 1, 0);
        add("e4", 1, 2'b00, 0, 1, 0, 32'hE4, 0, 0);

        repeat (2) @(posedge clk);
        foreach (tbl[i]) apply(tbl[i]);

        // Reset asserted mid-cycle must clear outputs without a clock edge.
        @(negedge clk);
        rst_n      = 1'b1;
        host_req   = 2'b01;
        dev_gnt    = 1'b1;
        dev_rvalid = 1'b0;
        #1;
        chk("m_pre_req", 64'(dev_req), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("m_rst_req", 64'(dev_req), 64'd0);
        chk("m_rst_gnt", 64'(host_gnt), 64'd0);
        chk("m_rst_addr", 64'(dev_addr), 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        host_req   = 2'b00;
        dev_rvalid = 1'b1;
        #1;
        chk("m_stale_rv", 64'(host_rvalid), 64'd0);
        chk("m_stale_rd", 64'(host_rdata), 64'd0);
        @(negedge clk);
        dev_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_host_arbiter.md
BUS_HOST_ARBITER -- requirements
Module: bus_host_arbiter

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of requesting hosts (2..8).
REQ-002 SHALL have parameter DataWidth, default 32, data bus width.
REQ-003 SHALL have parameter AddressWidth, default 32, address bus width.
REQ-004 SHALL have parameter MaxOutstanding, default 2, maximum granted-but-unanswered transactions (1..4).
REQ-005 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have ports host_req_i/host_we_i  input  1 [NrHosts]  per-host request and write-enable.
REQ-008 SHALL have ports host_addr_i, host_be_i, host_wdata_i  input  AddressWidth/4/DataWidth [NrHosts]  per-host request fields.
REQ-009 SHALL have ports host_gnt_o, host_rvalid_o, host_err_o  output  1 [NrHosts]  per-host grant, response valid, response error.
REQ-010 SHALL have port host_rdata_o  output  DataWidth [NrHosts]  per-host read data.
REQ-011 SHALL have ports dev_req_o, dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o  output  1/1/AddressWidth/4/DataWidth  shared device-side request.
REQ-012 SHALL have ports dev_gnt_i, dev_rvalid_i, dev_err_i  input  1  device grant, response valid, response error; dev_rdata_i  input  DataWidth  device read data.

Function
REQ-013 SHALL select one requesting host per cycle round-robin, starting search at host (last_granted+1) mod NrHosts.
REQ-014 SHALL drive dev_req_o=1 when any host requests and outstanding count < MaxOutstanding, with dev_* fields copied from the selected host.
REQ-015 SHALL hold the selection (sticky) while dev_req_o=1 and dev_gnt_i=0, regardless of other requests arriving.
REQ-016 SHALL assert host_gnt_o[sel] combinationally in the same cycle as dev_gnt_i && dev_req_o; all other host_gnt_o stay 0.
REQ-017 SHALL, on each grant, push the granted host index into a response-ID FIFO of depth MaxOutstanding and update last_granted.
REQ-018 SHALL route dev_rvalid_i, dev_err_i, dev_rdata_i to the host at FIFO head in the same cycle, then pop the head.
REQ-019 SHALL allow push and pop in the same cycle (count unchanged), including when count = MaxOutstanding.
REQ-020 SHALL hold dev_req_o=0 and all host_gnt_o=0 when count = MaxOutstanding and no pop occurs that cycle.
REQ-021 SHALL discard dev_rvalid_i received with an empty FIFO: no host_rvalid_o, no state change.
REQ-022 SHALL drive host_rdata_o of non-responding hosts to 0.
REQ-023 SHALL give wrap-around of FIFO pointers modulo MaxOutstanding and of the round-robin pointer modulo NrHosts.
REQ-024 SHALL drop the sticky selection if the selected host deasserts host_req_i before grant.

Reset
REQ-025 SHALL, on rst_ni low, immediately clear the FIFO (count 0), last_granted = NrHosts-1 (host 0 first), sticky flag 0.
REQ-026 SHALL hold all outputs at 0 during reset; outstanding transactions in flight at reset are forgotten and their responses discarded per REQ-021.

Configuration
REQ-027 SHALL, with BUS_ARB_FIXED_PRIO_EN defined, replace round-robin by fixed priority (lowest index wins), with REQ-015 stickiness kept.
REQ-028 SHALL, without BUS_ARB_FIXED_PRIO_EN, implement round-robin exactly per REQ-013.

Structure
REQ-029 SHALL place the host-index width function and the arbitration-mode enum in a shared package bus_arb_pkg.
REQ-030 SHALL implement the response-ID FIFO as sub-module bus_arb_id_fifo (parameters Depth, Width; push/pop/full/empty/head).

Verification
REQ-031 Both hosts request every cycle, dev_gnt_i=1, rvalid one cycle later -> grants alternate 0,1,0,1; each response reaches its issuer.
REQ-032 MaxOutstanding=2, rvalid withheld -> exactly 2 grants, then dev_req_o=0 until first rvalid; then one grant in the rvalid cycle.
REQ-033 Host 1 requests, dev_gnt_i=0 for 3 cycles while host 0 raises req -> dev_addr_o stays host 1's value; grant goes to host 1.
REQ-034 dev_rvalid_i=1, dev_rdata_i=32'hDEADBEEF with FIFO empty -> all host_rvalid_o=0, count stays 0.
REQ-035 Grant host 0 (addr 32'h100000), assert rst_ni=0 before rvalid -> outputs 0 immediately; post-reset stale rvalid discarded; next grant to host 0.
REQ-036 With BUS_ARB_FIXED_PRIO_EN, both hosts request continuously -> host 0 granted every cycle, host 1 never.
